// File: rtl/cnt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnt_seq_ctrl
// Description : Run sequencer for the 8-bit counter datapath: start, repeat,
//               auto-reload and abort control with period tick / done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [REP_W-1:0] cfg_repeat,
    input  logic             cfg_auto,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [REP_W-1:0] run_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [REP_W-1:0] r_repeat;
    logic [REP_W-1:0] r_run_idx;
    logic             r_auto;

    logic w_at_term;
    logic w_last_run;

    assign w_at_term  = (r_cnt == r_period);
    assign w_last_run = !r_auto && (r_run_idx == r_repeat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_run_idx <= '0;
            r_period  <= '0;
            r_repeat  <= '0;
            r_auto    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_period  <= cfg_period;
                        r_repeat  <= cfg_repeat;
                        r_auto    <= cfg_auto;
                        r_cnt     <= '0;
                        r_run_idx <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_cnt     <= '0;
                        r_run_idx <= '0;
                        r_state   <= ST_IDLE;
                    end else if (!w_at_term) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_last_run) begin
                        // cnt and run_idx freeze at P / R through DONE and into IDLE
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt     <= '0;
                        r_run_idx <= r_run_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // abort is the only input allowed to reach an output combinationally
    assign tick      = (r_state == ST_RUN) && w_at_term && !abort;
    assign done      = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN);
    assign cfg_ready = (r_state == ST_IDLE);
    assign cnt       = r_cnt;
    assign run_idx   = r_run_idx;

endmodule
`default_nettype wire

// File: tb/tb_cnt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_seq_ctrl
// Description : Scoreboard bench for cnt_seq_ctrl; timeline-based reference
//               model feeds per-cycle and tick/done event queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int REP_W = 4;
    localparam int C_IDX_MOD = 1 << REP_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period = '0;
    logic [REP_W-1:0] cfg_repeat = '0;
    logic             cfg_auto = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             done;
    logic             busy;
    logic [REP_W-1:0] run_idx;

    cnt_seq_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_period(cfg_period),
        .cfg_repeat(cfg_repeat),
        .cfg_auto  (cfg_auto),
        .abort     (abort),
        .cnt       (cnt),
        .tick      (tick),
        .done      (done),
        .busy      (busy),
        .run_idx   (run_idx)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int cnt;
        int idx;
        bit tick;
        bit done;
        bit busy;
        bit ready;
    } snap_t;

    typedef struct {
        int cyc;
        bit is_done;
        int idx;
    } evt_t;

    snap_t exp_q[$];
    evt_t  evt_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: a sequence is a timeline anchored at its first RUN cycle
    bit m_active = 0;
    int m_start = 0;
    int m_p = 0;
    int m_r = 0;
    bit m_auto = 0;
    int m_idle_cnt = 0;
    int m_idle_idx = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    task automatic step(input bit v, input int p, input int r, input bit au,
                        input bit ab, input bit rs);
        snap_t s;
        evt_t  e;
        int    t;
        int    len;
        @(posedge clk);
        #1;
        if (m_active && !m_auto) begin
            t   = edge_cnt - m_start;
            len = (m_r + 1) * (m_p + 1);
            if (t > len) begin
                m_active   = 0;
                m_idle_cnt = m_p;
                m_idle_idx = m_r;
            end
        end
        cfg_valid  = v;
        cfg_period = p[WIDTH-1:0];
        cfg_repeat = r[REP_W-1:0];
        cfg_auto   = au;
        abort      = ab;
        reset      = rs;

        s = '{default: 0};
        if (m_active) begin
            t   = edge_cnt - m_start;
            len = (m_r + 1) * (m_p + 1);
            if (m_auto || t < len) begin
                s.busy = 1;
                s.cnt  = t % (m_p + 1);
                s.idx  = (t / (m_p + 1)) % C_IDX_MOD;
                s.tick = (s.cnt == m_p) && !ab;
            end else begin
                s.done = 1;
                s.cnt  = m_p;
                s.idx  = m_r;
            end
        end else begin
            s.ready = 1;
            s.cnt   = m_idle_cnt;
            s.idx   = m_idle_idx;
        end
        exp_q.push_back(s);
        if (s.tick || s.done) begin
            e.cyc     = edge_cnt;
            e.is_done = s.done;
            e.idx     = s.idx;
            evt_q.push_back(e);
        end

        if (rs) begin
            m_active   = 0;
            m_idle_cnt = 0;
            m_idle_idx = 0;
        end else if (!m_active && v) begin
            m_active = 1;
            m_start  = edge_cnt + 1;
            m_p      = p;
            m_r      = r;
            m_auto   = au;
        end else if (s.busy && ab) begin
            m_active   = 0;
            m_idle_cnt = 0;
            m_idle_idx = 0;
        end
    endtask

    task automatic accept(input int p, input int r, input bit au);
        step(1, p, r, au, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: per-cycle snapshot plus ordered tick/done events
    initial begin
        snap_t s;
        evt_t  e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("cnt", int'(cnt), s.cnt);
                check("run_idx", int'(run_idx), s.idx);
                check("tick", int'(tick), int'(s.tick));
                check("done", int'(done), int'(s.done));
                check("busy", int'(busy), int'(s.busy));
                check("cfg_ready", int'(cfg_ready), int'(s.ready));
            end
            if (tick === 1'b1 || done === 1'b1) begin
                if (evt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event at cycle %0d: tick=%0b done=%0b, none expected",
                             edge_cnt, tick, done);
                end else begin
                    e = evt_q.pop_front();
                    check("evt_kind_done", int'(done), int'(e.is_done));
                    check("evt_cycle", edge_cnt, e.cyc);
                    check("evt_run_idx", int'(run_idx), e.idx);
                end
            end
        end
    end

    initial begin
        int p;
        int r;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 1);

        // single run with cfg_valid held (and ignored) through RUN and DONE
        accept(3, 0, 0);
        repeat (5) step(1, 7, 5, 0, 0, 0);
        idle(2);

        // degenerate period
        accept(0, 2, 0);
        idle(5);

        // maximum period, two runs
        accept(255, 1, 0);
        idle(516);

        // auto reload past the run index wrap, then abort
        accept(1, 0, 1);
        idle(40);
        step(0, 0, 0, 0, 1, 0);
        idle(2);

        // abort on the terminal of the final run, immediate re-accept
        accept(4, 1, 0);
        idle(9);
        step(1, 2, 0, 0, 1, 0);
        accept(2, 0, 0);
        idle(6);

        // reset held mid-run
        accept(10, 0, 0);
        idle(5);
        repeat (2) step(0, 0, 0, 0, 0, 1);
        idle(3);

        // randomized traffic
        repeat (3000) begin
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            step($urandom_range(0, 3) == 0, p, r, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 400) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        check("snapshot_queue_drained", exp_q.size(), 0);
        check("event_queue_drained", evt_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
